// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline hazard/flush controller.
package pipe_ctrl_pkg;
  localparam int unsigned CNT_W = 5;

  // Issue-to-result latency of the multiply/divide unit, in cycles.
  localparam logic [CNT_W-1:0] MULT_LAT = 5'd5;
  localparam logic [CNT_W-1:0] DIV_LAT  = 5'd10;

  // RUN: normal flow. EXC: one-cycle window after an exception/eret commits.
  typedef enum logic {
    RUN = 1'b0,
    EXC = 1'b1
  } ctrlState_e;
endpackage

// File: rtl/pipe_ctrl_mdu_busy_cnt.sv
// Multiply/divide busy counter: loads the unit latency on issue and counts down to 0.
// Only instantiated when PIPE_CTRL_MDU_EN is defined.
module mdu_busy_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  input  logic kill,
  output logic busy
);

  logic [CNT_W-1:0] cnt;

  // Load on an issue that is not killed, otherwise count down and saturate at 0.
  // A new start while a count is running is ignored; the running count continues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start && !kill && (cnt == '0)) begin
      cnt <= div ? DIV_LAT : MULT_LAT;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // An issue in the current cycle already counts as busy.
  always_comb begin
    busy = (cnt != '0) | start;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and flush controller: load-use and branch-operand stalls,
// multiply/divide busy stalls and exception/eret flush sequencing.
// Optional feature macro: PIPE_CTRL_MDU_EN (enables the MDU busy counter).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] RegAddrE,
  input  logic [4:0] RegAddrM,
  input  logic       RegWriteE,
  input  logic       MemtoRegE,
  input  logic       RegWriteM,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       MDUStartE,
  input  logic       MDUDivE,
  input  logic       MDUUseD,
  input  logic       ExcOccurM,
  input  logic       ERETM,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MDUBusy,
  output logic       ExcPend
);

  ctrlState_e state, stateNext;
  logic       excTrig;
  logic       hazard;
  logic       stallReq;
  logic       flushOverride;
  logic       matchE, matchM;
  logic       mduBusy;
  logic       unusedInputs;

  // Exception trigger is masked while in reset so flushes stay low there.
  always_comb begin
    excTrig = (ExcOccurM | ERETM) & reset;
  end

`ifdef PIPE_CTRL_MDU_EN
  logic cntBusy;

  mdu_busy_cnt uBusyCnt (
    .clk   (clk),
    .reset (reset),
    .start (MDUStartE),
    .div   (MDUDivE),
    .kill  (excTrig),
    .busy  (cntBusy)
  );

  // Busy is masked while in reset; the counter itself is already 0 there.
  always_comb begin
    mduBusy      = cntBusy & reset;
    unusedInputs = ^{RsE, RtE};
  end
`else
  // No MDU tracking: busy tied low and MDU issue inputs ignored.
  always_comb begin
    mduBusy      = 1'b0;
    unusedInputs = ^{RsE, RtE, MDUStartE, MDUDivE};
  end
`endif

  // Exception sequencing state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  // Hazard detection, next state and stall/flush outputs; flushes override stalls.
  always_comb begin
    stateNext = RUN;
    if (excTrig) begin
      stateNext = EXC;
    end

    matchE = (RegAddrE != '0) && ((RegAddrE == RsD) || (RegAddrE == RtD));
    matchM = (RegAddrM != '0) && ((RegAddrM == RsD) || (RegAddrM == RtD));

    hazard = (MemtoRegE & RegWriteE & matchE)
           | (BranchD & RegWriteE & matchE)
           | (BranchD & MemtoRegM & RegWriteM & matchM);

    stallReq      = hazard | (MDUUseD & mduBusy);
    flushOverride = excTrig | (state == EXC);

    StallF  = stallReq & ~flushOverride;
    StallD  = stallReq & ~flushOverride;
    FlushE  = (stallReq & ~flushOverride) | excTrig;
    FlushD  = flushOverride;
    FlushM  = excTrig;
    ExcPend = (state == EXC);
    MDUBusy = mduBusy;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (both PIPE_CTRL_MDU_EN builds).
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, RegAddrE, RegAddrM;
  logic       RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, BranchD;
  logic       MDUStartE, MDUDivE, MDUUseD, ExcOccurM, ERETM;
  logic       StallF, StallD, FlushD, FlushE, FlushM, MDUBusy, ExcPend;

  int unsigned errCnt = 0;
  int unsigned chkCnt = 0;

  pipe_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .RsD       (RsD),
    .RtD       (RtD),
    .RsE       (RsE),
    .RtE       (RtE),
    .RegAddrE  (RegAddrE),
    .RegAddrM  (RegAddrM),
    .RegWriteE (RegWriteE),
    .MemtoRegE (MemtoRegE),
    .RegWriteM (RegWriteM),
    .MemtoRegM (MemtoRegM),
    .BranchD   (BranchD),
    .MDUStartE (MDUStartE),
    .MDUDivE   (MDUDivE),
    .MDUUseD   (MDUUseD),
    .ExcOccurM (ExcOccurM),
    .ERETM     (ERETM),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .FlushM    (FlushM),
    .MDUBusy   (MDUBusy),
    .ExcPend   (ExcPend)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed as {StallF, StallD, FlushD, FlushE, FlushM}.
  task automatic checkOuts(input string tag, input logic [4:0] exp);
    checkVal(tag, {27'd0, StallF, StallD, FlushD, FlushE, FlushM}, {27'd0, exp});
  endtask

  task automatic clearIn();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0; RegAddrE = '0; RegAddrM = '0;
    RegWriteE = 0; MemtoRegE = 0; RegWriteM = 0; MemtoRegM = 0; BranchD = 0;
    MDUStartE = 0; MDUDivE = 0; MDUUseD = 0; ExcOccurM = 0; ERETM = 0;
  endtask

  // Advance to just after the next rising edge, ready to drive new inputs.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  int unsigned cnt;
  bit          done;

  initial begin
    clearIn();
    reset = 1'b0;
    #3;
    checkOuts("rstOuts", 5'b00000);
    checkVal("rstExcPend", ExcPend, 0);
    checkVal("rstBusy", MDUBusy, 0);
    MemtoRegE = 1; RegWriteE = 1; RegAddrE = 5'd5; RsD = 5'd5;
    #1 checkOuts("rstLoadUseComb", 5'b11010);
    clearIn();
    ExcOccurM = 1;
    #1 checkOuts("rstExcMasked", 5'b00000);
    clearIn();
    @(negedge clk);
    reset = 1'b1;

    // Load-use on Rs: one stall cycle, then the load has left E.
    nextCycle(); clearIn();
    MemtoRegE = 1; RegWriteE = 1; RegAddrE = 5'd5; RsD = 5'd5;
    #1 checkOuts("loadUseRs", 5'b11010);
    nextCycle(); clearIn();
    RegWriteM = 1; MemtoRegM = 1; RegAddrM = 5'd5; RsD = 5'd5;
    #1 checkOuts("loadUseAfter", 5'b00000);
    nextCycle(); clearIn();
    MemtoRegE = 1; RegWriteE = 1; RegAddrE = 5'd0; RsD = 5'd0;
    #1 checkOuts("loadUseReg0", 5'b00000);
    nextCycle(); clearIn();
    MemtoRegE = 1; RegWriteE = 1; RegAddrE = 5'd9; RtD = 5'd9; RsD = 5'd3;
    #1 checkOuts("loadUseRt", 5'b11010);
    nextCycle(); clearIn();
    RegWriteE = 1; RegAddrE = 5'd9; RtD = 5'd9;
    #1 checkOuts("aluNoBranch", 5'b00000);

    // Branch operand hazards.
    nextCycle(); clearIn();
    BranchD = 1; RtD = 5'd8; MemtoRegM = 1; RegWriteM = 1; RegAddrM = 5'd8;
    #1 checkOuts("branchLoadM", 5'b11010);
    nextCycle(); clearIn();
    BranchD = 1; RtD = 5'd8;
    #1 checkOuts("branchLoadDone", 5'b00000);
    nextCycle(); clearIn();
    BranchD = 1; RtD = 5'd8; RegWriteE = 1; RegAddrE = 5'd8;
    #1 checkOuts("branchAluE", 5'b11010);
    nextCycle(); clearIn();
    BranchD = 1; RtD = 5'd8; RegWriteM = 1; RegAddrM = 5'd8;
    #1 checkOuts("branchAluM", 5'b00000);
    nextCycle(); clearIn();
    BranchD = 1; RsD = 5'd0; RegWriteE = 1; RegAddrE = 5'd0;
    #1 checkOuts("branchReg0", 5'b00000);

    // Exception with load-use present: flushes win, then one EXC cycle.
    nextCycle(); clearIn();
    MemtoRegE = 1; RegWriteE = 1; RegAddrE = 5'd5; RsD = 5'd5; ExcOccurM = 1;
    #1 checkOuts("excTrigger", 5'b00111);
    checkVal("excTrigPend", ExcPend, 0);
    nextCycle(); clearIn();
    MemtoRegE = 1; RegWriteE = 1; RegAddrE = 5'd5; RsD = 5'd5;
    #1 checkVal("excPend", ExcPend, 1);
    checkVal("excFlushD", FlushD, 1);
    checkVal("excStallF", StallF, 0);
    checkVal("excStallD", StallD, 0);
    nextCycle(); clearIn();
    #1 checkVal("excBackRun", ExcPend, 0);
    checkOuts("excBackOuts", 5'b00000);

    // Back-to-back eret keeps EXC one more cycle.
    nextCycle(); clearIn();
    ERETM = 1;
    #1 checkOuts("eretTrig", 5'b00111);
    nextCycle(); clearIn();
    ERETM = 1;
    #1 checkOuts("eretRetrig", 5'b00111);
    checkVal("eretRetrigPend", ExcPend, 1);
    nextCycle(); clearIn();
    #1 checkVal("eretHoldPend", ExcPend, 1);
    checkVal("eretHoldFlushD", FlushD, 1);
    nextCycle(); clearIn();
    #1 checkVal("eretRun", ExcPend, 0);

`ifdef PIPE_CTRL_MDU_EN
    // Divide then HI/LO read: 10 stall cycles, proceeds on the 11th.
    nextCycle(); clearIn();
    MDUStartE = 1; MDUDivE = 1;
    #1 checkVal("divIssueBusy", MDUBusy, 1);
    nextCycle(); clearIn();
    MDUUseD = 1;
    cnt = 0; done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      #1;
      if (StallD === 1'b1) begin cnt++; nextCycle(); end
      else done = 1;
    end
    checkVal("divStallCycles", cnt, 10);
    checkVal("divProceedBusy", MDUBusy, 0);
    checkOuts("divProceedOuts", 5'b00000);

    nextCycle(); clearIn();
    MDUStartE = 1;
    nextCycle(); clearIn();
    MDUUseD = 1;
    cnt = 0; done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      #1;
      if (StallD === 1'b1) begin cnt++; nextCycle(); end
      else done = 1;
    end
    checkVal("multStallCycles", cnt, 5);

    // Issue killed by eret: counter never loads.
    nextCycle(); clearIn();
    MDUStartE = 1; MDUDivE = 1; ERETM = 1;
    #1 checkVal("killIssueBusy", MDUBusy, 1);
    nextCycle(); clearIn();
    #1 checkVal("killNextBusy", MDUBusy, 0);
    nextCycle(); clearIn();

    // Running count survives an exception.
    nextCycle(); clearIn();
    MDUStartE = 1; MDUDivE = 1;
    nextCycle(); clearIn();
    ExcOccurM = 1;
    cnt = 0; done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      #1;
      if (MDUBusy === 1'b1) begin cnt++; nextCycle(); clearIn(); end
      else done = 1;
    end
    checkVal("excKeepsCount", cnt, 10);
    nextCycle(); clearIn();

    // Asynchronous reset at counter=7.
    MDUStartE = 1; MDUDivE = 1;
    for (int i = 0; i < 4; i++) begin nextCycle(); clearIn(); end
    #1 checkVal("cnt7Busy", MDUBusy, 1);
    reset = 1'b0;
    #1 checkVal("asyncRstBusy", MDUBusy, 0);
    @(negedge clk);
    reset = 1'b1;
    nextCycle(); clearIn();
    MDUUseD = 1;
    #1 checkOuts("postRstNoStall", 5'b00000);
    checkVal("postRstBusy", MDUBusy, 0);
`else
    // MDU tracking compiled out: MDU inputs have no effect.
    nextCycle(); clearIn();
    MDUStartE = 1; MDUDivE = 1; MDUUseD = 1;
    #1 checkVal("noMduBusy", MDUBusy, 0);
    checkOuts("noMduOuts", 5'b00000);
    nextCycle(); clearIn();
    MDUUseD = 1;
    #1 checkVal("noMduNextBusy", MDUBusy, 0);
    checkOuts("noMduNextOuts", 5'b00000);
`endif

    // Asynchronous reset while in EXC.
    nextCycle(); clearIn();
    ExcOccurM = 1;
    nextCycle(); clearIn();
    #1 checkVal("excBeforeRst", ExcPend, 1);
    reset = 1'b0;
    #1 checkVal("asyncRstExc", ExcPend, 0);
    checkOuts("asyncRstExcOuts", 5'b00000);
    @(negedge clk);
    reset = 1'b1;
    nextCycle(); clearIn();
    #1 checkVal("postRstRun", ExcPend, 0);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
